// File: rtl/alu_arbiter_pkg.sv
// alu_arbiter shared types: opcode encoding, FSM state type
// and the multi-cycle opcode predicate.
package alu_arbiter_pkg;

   typedef enum logic [3:0] {
      OP_ADD  = 4'd0,
      OP_SUB  = 4'd1,
      OP_AND  = 4'd2,
      OP_OR   = 4'd3,
      OP_XOR  = 4'd4,
      OP_SLL  = 4'd5,
      OP_SRL  = 4'd6,
      OP_SRA  = 4'd7,
      OP_MUL  = 4'd8,
      OP_MULH = 4'd9,
      OP_DIV  = 4'd10,
      OP_REM  = 4'd11,
      OP_SLT  = 4'd12,
      OP_SLTU = 4'd13
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // mul, mulh, div and rem need MC_LATENCY exec cycles
   function automatic logic is_multicycle(logic [3:0] op);
      return (op >= 4'(OP_MUL)) && (op <= 4'(OP_REM));
   endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// Requester, shared-ALU and response signals of alu_arbiter.
// slave = arbiter side, master = requesters/ALU/consumer side.
interface alu_arbiter_if;

   logic        req0_valid;
   logic        req0_ready;
   logic [63:0] req0_x;
   logic [63:0] req0_y;
   logic [3:0]  req0_op;

   logic        req1_valid;
   logic        req1_ready;
   logic [63:0] req1_x;
   logic [63:0] req1_y;
   logic [3:0]  req1_op;

   logic [63:0] alu_x;
   logic [63:0] alu_y;
   logic [3:0]  alu_op;
   logic [63:0] alu_result;
   logic        alu_is_equal;

   logic        rsp_valid;
   logic        rsp_ready;
   logic [63:0] rsp_result;
   logic        rsp_is_equal;
   logic        rsp_id;

   modport slave (
      input  req0_valid, req0_x, req0_y, req0_op,
      input  req1_valid, req1_x, req1_y, req1_op,
      output req0_ready, req1_ready,
      output alu_x, alu_y, alu_op,
      input  alu_result, alu_is_equal,
      output rsp_valid, rsp_result, rsp_is_equal, rsp_id,
      input  rsp_ready
   );

   modport master (
      output req0_valid, req0_x, req0_y, req0_op,
      output req1_valid, req1_x, req1_y, req1_op,
      input  req0_ready, req1_ready,
      input  alu_x, alu_y, alu_op,
      output alu_result, alu_is_equal,
      input  rsp_valid, rsp_result, rsp_is_equal, rsp_id,
      output rsp_ready
   );

endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared
// combinational ALU; one operation in flight at a time.
module alu_arbiter
   import alu_arbiter_pkg::*;
#(
   parameter int MC_LATENCY = 4
) (
   input logic           clk,
   input logic           rst,
   alu_arbiter_if.slave  bus
);

   localparam int CW = $clog2(MC_LATENCY + 1) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MC_LATENCY - 1);

   state_e        state_q;
   state_e        state_d;

   logic          grant;
   logic          last_q;

   logic [63:0]   cap_x_q;
   logic [63:0]   cap_y_q;
   logic [3:0]    cap_op_q;
   logic          cap_id_q;
   logic [CW-1:0] cnt_q;

   logic [63:0]   rsp_result_q;
   logic          rsp_eq_q;
   logic          rsp_id_q;

   logic          ready0;
   logic          ready1;
   logic          accept;
   logic          sample;
   logic          rsp_fire;
   logic          rsp_valid;

   // round-robin: favour the requester not served last
   always_comb begin
      grant = 1'b0;
      if (bus.req0_valid && bus.req1_valid)
         grant = ~last_q;
      else if (bus.req1_valid)
         grant = 1'b1;
   end

   // state register
   always_ff @(posedge clk) begin
      if (rst)
         state_q <= ST_IDLE;
      else
         state_q <= state_d;
   end

   // next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: if (accept)   state_d = ST_EXEC;
         ST_EXEC: if (sample)   state_d = ST_RESP;
         ST_RESP: if (rsp_fire) state_d = ST_IDLE;
         default:               state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: readys only in IDLE, sample point in EXEC
   always_comb begin
      ready0    = 1'b0;
      ready1    = 1'b0;
      sample    = 1'b0;
      rsp_valid = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            ready0 = bus.req0_valid && !grant && !rst;
            ready1 = bus.req1_valid &&  grant && !rst;
         end
         ST_EXEC: begin
            if (is_multicycle(cap_op_q))
               sample = (cnt_q == CNT_LAST);
            else
               sample = 1'b1;
         end
         ST_RESP: rsp_valid = 1'b1;
         default: ;
      endcase
   end

   assign accept   = ready0 | ready1;
   assign rsp_fire = rsp_valid & bus.rsp_ready;

   // operand capture, exec counter, response and rr state
   always_ff @(posedge clk) begin
      if (rst) begin
         cap_x_q      <= '0;
         cap_y_q      <= '0;
         cap_op_q     <= '0;
         cap_id_q     <= 1'b0;
         cnt_q        <= '0;
         rsp_result_q <= '0;
         rsp_eq_q     <= 1'b0;
         rsp_id_q     <= 1'b0;
         last_q       <= 1'b1;
      end else begin
         if (accept) begin
            cap_x_q  <= grant ? bus.req1_x  : bus.req0_x;
            cap_y_q  <= grant ? bus.req1_y  : bus.req0_y;
            cap_op_q <= grant ? bus.req1_op : bus.req0_op;
            cap_id_q <= grant;
            cnt_q    <= '0;
         end else if (state_q == ST_EXEC) begin
            cnt_q <= cnt_q + 1'b1;
         end
         if (sample) begin
            rsp_result_q <= bus.alu_result;
            rsp_eq_q     <= bus.alu_is_equal;
            rsp_id_q     <= cap_id_q;
            last_q       <= cap_id_q;
         end
      end
   end

   assign bus.req0_ready   = ready0;
   assign bus.req1_ready   = ready1;
   assign bus.alu_x        = cap_x_q;
   assign bus.alu_y        = cap_y_q;
   assign bus.alu_op       = cap_op_q;
   assign bus.rsp_valid    = rsp_valid;
   assign bus.rsp_result   = rsp_result_q;
   assign bus.rsp_is_equal = rsp_eq_q;
   assign bus.rsp_id       = rsp_id_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural shared ALU.
// Inputs change 1ns after posedge; outputs checked mid-cycle.
`timescale 1ns/1ps
module tb_alu_arbiter;
   import alu_arbiter_pkg::*;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_bad;

   alu_arbiter_if bus ();

   alu_arbiter #(.MC_LATENCY(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // behavioural shared ALU
   always_comb begin
      logic [127:0] p;
      p = $signed(bus.alu_x) * $signed(bus.alu_y);
      bus.alu_is_equal = (bus.alu_x == bus.alu_y);
      case (bus.alu_op)
         4'd1:  bus.alu_result = bus.alu_x - bus.alu_y;
         4'd2:  bus.alu_result = bus.alu_x & bus.alu_y;
         4'd3:  bus.alu_result = bus.alu_x | bus.alu_y;
         4'd4:  bus.alu_result = bus.alu_x ^ bus.alu_y;
         4'd5:  bus.alu_result = bus.alu_x << bus.alu_y[5:0];
         4'd6:  bus.alu_result = bus.alu_x >> bus.alu_y[5:0];
         4'd7:  bus.alu_result = $signed(bus.alu_x) >>> bus.alu_y[5:0];
         4'd8:  bus.alu_result = bus.alu_x * bus.alu_y;
         4'd9:  bus.alu_result = p[127:64];
         4'd10: bus.alu_result = (bus.alu_y == 0) ? '1 :
                   64'($signed(bus.alu_x) / $signed(bus.alu_y));
         4'd11: bus.alu_result = (bus.alu_y == 0) ? bus.alu_x :
                   64'($signed(bus.alu_x) % $signed(bus.alu_y));
         4'd12: bus.alu_result =
                   {63'd0, $signed(bus.alu_x) < $signed(bus.alu_y)};
         4'd13: bus.alu_result = {63'd0, bus.alu_x < bus.alu_y};
         default: bus.alu_result = bus.alu_x + bus.alu_y;
      endcase
   end

   task automatic check(input string tag,
                        input logic [63:0] got,
                        input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive0(input logic v, input logic [3:0] op,
                         input logic [63:0] x, input logic [63:0] y);
      bus.req0_valid = v;
      bus.req0_op    = op;
      bus.req0_x     = x;
      bus.req0_y     = y;
   endtask

   task automatic drive1(input logic v, input logic [3:0] op,
                         input logic [63:0] x, input logic [63:0] y);
      bus.req1_valid = v;
      bus.req1_op    = op;
      bus.req1_x     = x;
      bus.req1_y     = y;
   endtask

   // wait (bounded) until rsp_valid is high
   task automatic wait_rsp(input string tag);
      int k;
      k = 0;
      while (!bus.rsp_valid && k < 20) begin
         tick();
         k++;
      end
      if (!bus.rsp_valid) check({tag, "_timeout"}, 0, 1);
   endtask

   initial begin
      logic quiet;
      logic g;
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      bus.rsp_ready = 1'b0;
      drive0(1'b1, 4'd0, 64'd1, 64'd1);
      drive1(1'b1, 4'd0, 64'd2, 64'd2);
      tick();
      tick();
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_result", bus.rsp_result, 0);
      check("rst_rsp_id", bus.rsp_id, 0);
      check("rst_alu_x", bus.alu_x, 0);
      check("rst_alu_op", bus.alu_op, 0);
      drive0(1'b0, 4'd0, 64'd0, 64'd0);
      drive1(1'b0, 4'd0, 64'd0, 64'd0);
      rst = 1'b0;

      // single-cycle add from req0
      bus.rsp_ready = 1'b1;
      drive0(1'b1, 4'(OP_ADD), 64'd5, 64'd7);
      #1;
      check("add_ready0", bus.req0_ready, 1);
      check("add_ready1", bus.req1_ready, 0);
      tick();
      drive0(1'b0, 4'd0, 64'd0, 64'd0);
      check("add_c1_valid", bus.rsp_valid, 0);
      tick();
      check("add_c2_valid", bus.rsp_valid, 1);
      check("add_result", bus.rsp_result, 64'd12);
      check("add_id", bus.rsp_id, 0);
      check("add_eq", bus.rsp_is_equal, 0);
      tick();
      check("add_back_idle", bus.rsp_valid, 0);

      // multi-cycle div from req1
      drive1(1'b1, 4'(OP_DIV), 64'd100, 64'd7);
      #1;
      check("div_ready1", bus.req1_ready, 1);
      tick();
      drive1(1'b0, 4'd0, 64'd0, 64'd0);
      for (int c = 1; c <= 4; c++) begin
         check($sformatf("div_x_c%0d", c), bus.alu_x, 64'd100);
         check($sformatf("div_y_c%0d", c), bus.alu_y, 64'd7);
         check($sformatf("div_op_c%0d", c), bus.alu_op, 64'd10);
         check($sformatf("div_nv_c%0d", c), bus.rsp_valid, 0);
         tick();
      end
      check("div_c5_valid", bus.rsp_valid, 1);
      check("div_result", bus.rsp_result, 64'd14);
      check("div_id", bus.rsp_id, 1);
      tick();

      // round-robin with both requesters always valid
      rst = 1'b1;
      tick();
      rst = 1'b0;
      drive0(1'b1, 4'(OP_SUB), 64'd50, 64'd8);
      drive1(1'b1, 4'(OP_SUB), 64'd9, 64'd9);
      for (int i = 0; i < 4; i++) begin
         int k;
         k = 0;
         #1;
         while (!(bus.req0_ready || bus.req1_ready) && k < 20) begin
            tick();
            k++;
         end
         check($sformatf("rr_hs_%0d", i),
               bus.req0_ready ^ bus.req1_ready, 1);
         g = bus.req1_ready;
         check($sformatf("rr_grant_%0d", i), g, 64'(i % 2));
         tick();
         wait_rsp("rr");
         check($sformatf("rr_id_%0d", i), bus.rsp_id, g);
         check($sformatf("rr_res_%0d", i), bus.rsp_result,
               g ? 64'd0 : 64'd42);
         check($sformatf("rr_eq_%0d", i), bus.rsp_is_equal, g);
         tick();
      end

      // response stall for 6 cycles
      bus.rsp_ready = 1'b0;
      drive0(1'b1, 4'(OP_XOR), 64'hF0, 64'h0F);
      #1;
      check("stl_ready0", bus.req0_ready, 1);
      tick();
      tick();
      for (int c = 0; c < 6; c++) begin
         check($sformatf("stl_v_%0d", c), bus.rsp_valid, 1);
         check($sformatf("stl_r_%0d", c), bus.rsp_result, 64'hFF);
         check($sformatf("stl_id_%0d", c), bus.rsp_id, 0);
         check($sformatf("stl_rd_%0d", c),
               {bus.req0_ready, bus.req1_ready}, 0);
         tick();
      end
      bus.rsp_ready = 1'b1;
      #1;
      check("stl_still_valid", bus.rsp_valid, 1);
      tick();
      check("stl_idle_valid", bus.rsp_valid, 0);
      check("stl_next_ready1", bus.req1_ready, 1);
      check("stl_next_ready0", bus.req0_ready, 0);
      drive0(1'b0, 4'd0, 64'd0, 64'd0);
      drive1(1'b0, 4'd0, 64'd0, 64'd0);
      tick();

      // reset in the middle of a mul
      drive0(1'b1, 4'(OP_MUL), 64'd3, 64'd4);
      #1;
      check("mrst_ready0", bus.req0_ready, 1);
      tick();
      drive0(1'b0, 4'd0, 64'd0, 64'd0);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mrst_valid", bus.rsp_valid, 0);
      check("mrst_alu_x", bus.alu_x, 0);
      quiet = 1'b1;
      for (int c = 0; c < 6; c++) begin
         if (bus.rsp_valid) quiet = 1'b0;
         tick();
      end
      check("mrst_no_rsp", quiet, 1);
      drive1(1'b1, 4'(OP_ADD), 64'd1, 64'd2);
      #1;
      check("mrst_r1_ready", bus.req1_ready, 1);
      tick();
      drive1(1'b0, 4'd0, 64'd0, 64'd0);
      tick();
      check("mrst_r1_valid", bus.rsp_valid, 1);
      check("mrst_r1_id", bus.rsp_id, 1);
      check("mrst_r1_res", bus.rsp_result, 64'd3);
      tick();
      drive0(1'b1, 4'(OP_ADD), 64'd10, 64'd10);
      drive1(1'b1, 4'(OP_ADD), 64'd20, 64'd20);
      #1;
      check("mrst_both_r0", bus.req0_ready, 1);
      check("mrst_both_r1", bus.req1_ready, 0);
      tick();
      drive0(1'b0, 4'd0, 64'd0, 64'd0);
      drive1(1'b0, 4'd0, 64'd0, 64'd0);
      tick();
      check("mrst_both_res", bus.rsp_result, 64'd20);
      check("mrst_both_id", bus.rsp_id, 0);
      check("mrst_both_eq", bus.rsp_is_equal, 1);
      tick();

      // sltu on equal all-ones operands
      drive0(1'b1, 4'(OP_SLTU), '1, '1);
      #1;
      check("sltu_ready0", bus.req0_ready, 1);
      tick();
      drive0(1'b0, 4'd0, 64'd0, 64'd0);
      tick();
      check("sltu_valid", bus.rsp_valid, 1);
      check("sltu_res", bus.rsp_result, 64'd0);
      check("sltu_eq", bus.rsp_is_equal, 1);
      tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
